// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular arbiter sharing the MAC's 8-bit AXI-stream TX input between S_COUNT sources.
// One source owns the MAC from grant to tlast; oversize frames are truncated, flagged, and the tail sunk.
module eth_tx_frame_arbiter #(
    parameter int unsigned S_COUNT         = 4,
    parameter int unsigned ARB_ROUND_ROBIN = 1,
    parameter int unsigned MAX_FRAME_LEN   = 1514
) (
    input  logic                 logic_clk,
    input  logic                 logic_rst_n,

    input  logic [8*S_COUNT-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]   s_axis_tvalid,
    output logic [S_COUNT-1:0]   s_axis_tready,
    input  logic [S_COUNT-1:0]   s_axis_tlast,
    input  logic [S_COUNT-1:0]   s_axis_tuser,

    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,

    output logic                 grant_valid,
    output logic [2:0]           grant_index,
    output logic                 err_oversize
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  grant_next;
    logic [2:0]  prio;
    logic [2:0]  prio_next;
    logic [15:0] beat_cnt;
    logic [15:0] beat_cnt_next;
    logic        err_next;

    // Source buses widened to 8 lanes so a 3-bit grant indexes them without range issues.
    logic [7:0]  valid_pad;
    logic [7:0]  last_pad;
    logic [7:0]  user_pad;
    logic [7:0]  ready_pad;
    logic [63:0] data_pad;

    assign valid_pad     = 8'(s_axis_tvalid);
    assign last_pad      = 8'(s_axis_tlast);
    assign user_pad      = 8'(s_axis_tuser);
    assign data_pad      = 64'(s_axis_tdata);
    assign s_axis_tready = ready_pad[S_COUNT-1:0];

    logic       src_valid;
    logic       src_last;
    logic       src_user;
    logic [7:0] src_data;
    logic       at_limit;
    logic       trunc;
    logic       accept;
    logic [2:0] prio_after;

    assign src_valid = valid_pad[grant_index];
    assign src_last  = last_pad[grant_index];
    assign src_user  = user_pad[grant_index];
    assign src_data  = data_pad[{grant_index, 3'b000} +: 8];
    assign at_limit  = (beat_cnt == 16'(MAX_FRAME_LEN - 1));
    assign trunc     = at_limit && !src_last;
    assign accept    = src_valid && m_axis_tready;

    assign prio_after = (ARB_ROUND_ROBIN == 0) ? 3'd0 :
                        (grant_index == 3'(S_COUNT - 1)) ? 3'd0 : grant_index + 3'd1;

    logic [2:0] arb_start;
    logic [3:0] arb_cand;
    logic       arb_found;
    logic [2:0] arb_idx;

    assign arb_start = (ARB_ROUND_ROBIN == 0) ? 3'd0 : prio;

    // First requester at or after arb_start, wrapping modulo S_COUNT.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int unsigned k = 0; k < S_COUNT; k++) begin
            arb_cand = 4'(arb_start) + 4'(k);
            if (arb_cand >= 4'(S_COUNT)) begin
                arb_cand = arb_cand - 4'(S_COUNT);
            end
            if (!arb_found && valid_pad[arb_cand[2:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand[2:0];
            end
        end
    end

    always_comb begin
        state_next    = state;
        grant_next    = grant_index;
        prio_next     = prio;
        beat_cnt_next = beat_cnt;
        err_next      = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        ready_pad     = '0;

        unique case (state)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_next    = arb_idx;
                    beat_cnt_next = '0;
                    state_next    = ST_PASS;
                end
            end
            ST_PASS: begin
                m_axis_tdata           = src_data;
                m_axis_tvalid          = src_valid;
                m_axis_tlast           = src_last || trunc;
                m_axis_tuser           = src_user || trunc;
                ready_pad[grant_index] = m_axis_tready;
                if (accept) begin
                    beat_cnt_next = beat_cnt + 16'd1;
                    if (src_last) begin
                        state_next = ST_IDLE;
                        prio_next  = prio_after;
                    end else if (trunc) begin
                        state_next = ST_DROP;
                        err_next   = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                ready_pad[grant_index] = 1'b1;
                if (src_valid && src_last) begin
                    state_next = ST_IDLE;
                    prio_next  = prio_after;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge logic_clk) begin
        if (!logic_rst_n) begin
            state        <= ST_IDLE;
            grant_index  <= '0;
            prio         <= '0;
            beat_cnt     <= '0;
            err_oversize <= 1'b0;
        end else begin
            state        <= state_next;
            grant_index  <= grant_next;
            prio         <= prio_next;
            beat_cnt     <= beat_cnt_next;
            err_oversize <= err_next;
        end
    end

    assign grant_valid = (state != ST_IDLE);

endmodule
